// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// round-robin grants and an in-order owner queue that steers each response back.

module mem_port_arbiter_chk (
    input  logic clk,
    input  logic rst,
    input  logic mem_resp_valid,
    input  logic queue_empty
);

    a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp_valid && queue_empty));

endmodule

module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_req_a,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [XLEN-1:0]   ls_req_a,
    input  logic [XLEN-1:0]   ls_req_d,
    input  logic              ls_req_we,
    input  logic [XLEN/8-1:0] ls_req_be,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_a,
    output logic [XLEN-1:0]   mem_req_d,
    output logic              mem_req_we,
    output logic [XLEN/8-1:0] mem_req_be,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [XLEN-1:0]   mem_resp_data,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [XLEN-1:0]   if_resp_data,
    output logic              ls_resp_valid,
    input  logic              ls_resp_ready,
    output logic [XLEN-1:0]   ls_resp_data
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = XLEN / 8;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [CW-1:0]              count_q, count_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [MAX_OUTSTANDING-1:0] kill_q, kill_d;
    logic                       lock_q, lock_d;
    logic                       lock_owner_q, lock_owner_d;
    logic                       last_grant_q, last_grant_d;
    logic                       active_q, active_d;

    logic live_s, issue_ok_s, if_v_s, gnt_s, gnt_valid_s;
    logic push_s, pop_s, head_owner_s, head_kill_s, resp_ready_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Arbitration: a locked grant holds until it fires; a locked fetch retracts on flush.
    always_comb begin
        live_s      = rst && active_q;
        issue_ok_s  = live_s && (count_q < CW'(MAX_OUTSTANDING));
        if_v_s      = if_req_valid && !flush;
        gnt_s       = OWN_LS;
        gnt_valid_s = 1'b0;
        if (lock_q) begin
            gnt_s       = lock_owner_q;
            gnt_valid_s = (lock_owner_q == OWN_LS) ? ls_req_valid : if_v_s;
        end else if (ls_req_valid && if_v_s) begin
            gnt_s       = ~last_grant_q;
            gnt_valid_s = 1'b1;
        end else if (ls_req_valid) begin
            gnt_s       = OWN_LS;
            gnt_valid_s = 1'b1;
        end else if (if_v_s) begin
            gnt_s       = OWN_IF;
            gnt_valid_s = 1'b1;
        end else begin
            gnt_s       = OWN_LS;
            gnt_valid_s = 1'b0;
        end
    end

    // Request mux toward memory and ready back to the granted requester.
    always_comb begin
        mem_req_valid = gnt_valid_s && issue_ok_s;
        if (gnt_s == OWN_LS) begin
            mem_req_a  = ls_req_a;
            mem_req_d  = ls_req_d;
            mem_req_we = ls_req_we;
            mem_req_be = ls_req_be;
        end else begin
            mem_req_a  = if_req_a;
            mem_req_d  = {XLEN{1'b0}};
            mem_req_we = 1'b0;
            mem_req_be = {BW{1'b0}};
        end
        ls_req_ready = gnt_valid_s && (gnt_s == OWN_LS) && mem_req_ready && issue_ok_s;
        if_req_ready = gnt_valid_s && (gnt_s == OWN_IF) && mem_req_ready && issue_ok_s;
        push_s       = mem_req_valid && mem_req_ready;
    end

    // Response steering by queue head; killed fetches are swallowed here.
    always_comb begin
        head_owner_s  = owner_q[rd_ptr_q];
        head_kill_s   = kill_q[rd_ptr_q] || (flush && (head_owner_s == OWN_IF));
        resp_ready_s  = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        if (live_s && (count_q != {CW{1'b0}})) begin
            if (head_kill_s) begin
                resp_ready_s = 1'b1;
            end else if (head_owner_s == OWN_LS) begin
                ls_resp_valid = mem_resp_valid;
                resp_ready_s  = ls_resp_ready;
            end else begin
                if_resp_valid = mem_resp_valid;
                resp_ready_s  = if_resp_ready;
            end
        end else begin
            resp_ready_s = 1'b0;
        end
        pop_s = mem_resp_valid && resp_ready_s;
    end

    assign mem_resp_ready = resp_ready_s;
    assign if_resp_data   = mem_resp_data;
    assign ls_resp_data   = mem_resp_data;

    // Next-state for queue, pointers, lock and round-robin history.
    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        owner_d      = owner_q;
        kill_d       = kill_q;
        last_grant_d = push_s ? gnt_s : last_grant_q;
        lock_owner_d = lock_owner_q;
        lock_d       = lock_q;
        active_d     = 1'b1;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_s) begin
            owner_d[wr_ptr_q] = gnt_s;
            kill_d[wr_ptr_q]  = 1'b0;
        end else begin
            owner_d = owner_q;
        end
        if (flush) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (owner_d[i] == OWN_IF) begin
                    kill_d[i] = 1'b1;
                end else begin
                    kill_d[i] = kill_d[i];
                end
            end
        end else begin
            kill_d = kill_d;
        end
        if (push_s) begin
            lock_d = 1'b0;
        end else if (lock_q && (lock_owner_q == OWN_IF) && flush) begin
            lock_d = 1'b0;
        end else if (mem_req_valid && !mem_req_ready) begin
            lock_d       = 1'b1;
            lock_owner_d = gnt_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q      <= {CW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            owner_q      <= {MAX_OUTSTANDING{1'b0}};
            kill_q       <= {MAX_OUTSTANDING{1'b0}};
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_IF;
            last_grant_q <= OWN_IF;
            active_q     <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            owner_q      <= owner_d;
            kill_q       <= kill_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            last_grant_q <= last_grant_d;
            active_q     <= active_d;
        end
    end

    mem_port_arbiter_chk u_chk (
        .clk            (clk),
        .rst            (rst),
        .mem_resp_valid (mem_resp_valid),
        .queue_empty    (count_q == {CW{1'b0}})
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each task drives one scenario and checks inline.

module tb_mem_port_arbiter;

    logic        clk, rst, flush;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_a;
    logic        ls_req_valid, ls_req_ready;
    logic [31:0] ls_req_a, ls_req_d;
    logic        ls_req_we;
    logic [3:0]  ls_req_be;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_a, mem_req_d;
    logic        mem_req_we;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic        if_resp_valid, if_resp_ready;
    logic [31:0] if_resp_data;
    logic        ls_resp_valid, ls_resp_ready;
    logic [31:0] ls_resp_data;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_a(if_req_a),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_a(ls_req_a),
        .ls_req_d(ls_req_d), .ls_req_we(ls_req_we), .ls_req_be(ls_req_be),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_a(mem_req_a),
        .mem_req_d(mem_req_d), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
        .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready), .ls_resp_data(ls_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        if_req_valid = 1'b0; if_req_a = 32'h0;
        ls_req_valid = 1'b0; ls_req_a = 32'h0; ls_req_d = 32'h0;
        ls_req_we = 1'b0; ls_req_be = 4'h0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        if_req_valid = 1'b1; if_req_a = 32'h2000;
        ls_req_valid = 1'b1; ls_req_a = 32'h100;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (mem_req_valid !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_outputs cyc=%0d mem_req_valid=%b if_resp_valid=%b ls_resp_valid=%b want 0", c, mem_req_valid, if_resp_valid, ls_resp_valid);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if (mem_req_valid !== 1'b0 || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_after_cycle mem_req_valid=%b if_req_ready=%b ls_req_ready=%b want 0", mem_req_valid, if_req_ready, ls_req_ready);
        end
        tick();
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_a !== 32'h100 || ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_first_grant valid=%b a=%h ls_rdy=%b if_rdy=%b want 1 00000100 1 0", mem_req_valid, mem_req_a, ls_req_ready, if_req_ready);
        end
        tick();
        total++;
        if (mem_req_a !== 32'h2000 || mem_req_we !== 1'b0 || if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_second_grant a=%h we=%b if_rdy=%b ls_rdy=%b want 00002000 0 1 0", mem_req_a, mem_req_we, if_req_ready, ls_req_ready);
        end
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hA1;
        #1;
        total++;
        if (ls_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || ls_resp_data !== 32'hA1) begin
            bad++;
            $display("FAIL rst_resp_ls ls_v=%b if_v=%b data=%h want 1 0 000000a1", ls_resp_valid, if_resp_valid, ls_resp_data);
        end
        tick();
        mem_resp_data = 32'hA2;
        #1;
        total++;
        if (if_resp_valid !== 1'b1 || ls_resp_valid !== 1'b0 || if_resp_data !== 32'hA2) begin
            bad++;
            $display("FAIL rst_resp_if if_v=%b ls_v=%b data=%h want 1 0 000000a2", if_resp_valid, ls_resp_valid, if_resp_data);
        end
        tick();
        idle();
    endtask

    task automatic test_alternate();
        logic exp_ls;
        logic prev_ls;
        idle();
        ls_req_a = 32'h100; if_req_a = 32'h2000;
        for (int i = 0; i < 5; i++) begin
            ls_req_valid = (i < 4); if_req_valid = (i < 4);
            mem_resp_valid = (i >= 1); mem_resp_data = 32'h5000 + i;
            #1;
            exp_ls = ((i % 2) == 0);
            prev_ls = (((i - 1) % 2) == 0);
            if (i < 4) begin
                total++;
                if (mem_req_valid !== 1'b1 || mem_req_a !== (exp_ls ? 32'h100 : 32'h2000)) begin
                    bad++;
                    $display("FAIL alt_grant i=%0d valid=%b a=%h want LS=%b", i, mem_req_valid, mem_req_a, exp_ls);
                end
            end
            if (i >= 1) begin
                total++;
                if (ls_resp_valid !== prev_ls || if_resp_valid !== !prev_ls || mem_resp_ready !== 1'b1 || ls_resp_data !== 32'h5000 + i) begin
                    bad++;
                    $display("FAIL alt_resp i=%0d ls_v=%b if_v=%b rdy=%b data=%h want ls_v=%b", i, ls_resp_valid, if_resp_valid, mem_resp_ready, ls_resp_data, prev_ls);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_lock();
        idle();
        ls_req_valid = 1'b1; ls_req_a = 32'h200; ls_req_d = 32'hDEADBEEF;
        ls_req_we = 1'b1; ls_req_be = 4'hF;
        if_req_valid = 1'b1; if_req_a = 32'h2000;
        mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (mem_req_valid !== 1'b1 || mem_req_a !== 32'h200 || mem_req_d !== 32'hDEADBEEF || mem_req_we !== 1'b1 || mem_req_be !== 4'hF || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL lock_ls_stall c=%0d v=%b a=%h d=%h we=%b be=%h if_rdy=%b ls_rdy=%b", c, mem_req_valid, mem_req_a, mem_req_d, mem_req_we, mem_req_be, if_req_ready, ls_req_ready);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        total++;
        if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL lock_ls_fire ls_rdy=%b if_rdy=%b want 1 0", ls_req_ready, if_req_ready);
        end
        tick();
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_be = 4'h0;
        if_req_a = 32'h2004;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h11;
        #1;
        total++;
        if (ls_resp_valid !== 1'b1 || mem_req_a !== 32'h2004 || if_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL lock_if_issue ls_v=%b a=%h if_rdy=%b want 1 00002004 1", ls_resp_valid, mem_req_a, if_req_ready);
        end
        tick();
        if_req_a = 32'h2008; mem_req_ready = 1'b0; mem_resp_data = 32'h22;
        #1;
        total++;
        if (if_resp_valid !== 1'b1 || if_resp_data !== 32'h22 || mem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL lock_if_stall if_v=%b data=%h req_v=%b want 1 00000022 1", if_resp_valid, if_resp_data, mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        ls_req_valid = 1'b1; ls_req_a = 32'h300;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_a !== 32'h2008 || ls_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL lock_if_hold v=%b a=%h ls_rdy=%b want 1 00002008 0", mem_req_valid, mem_req_a, ls_req_ready);
        end
        tick();
        flush = 1'b1;
        #1;
        total++;
        if (mem_req_valid !== 1'b0 || if_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL lock_if_retract v=%b if_rdy=%b want 0 0", mem_req_valid, if_req_ready);
        end
        tick();
        flush = 1'b0; if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_a !== 32'h300 || ls_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL lock_release v=%b a=%h ls_rdy=%b want 1 00000300 1", mem_req_valid, mem_req_a, ls_req_ready);
        end
        tick();
        ls_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h33;
        #1;
        total++;
        if (ls_resp_valid !== 1'b1 || ls_resp_data !== 32'h33) begin
            bad++;
            $display("FAIL lock_ls_resp ls_v=%b data=%h want 1 00000033", ls_resp_valid, ls_resp_data);
        end
        tick();
        idle();
    endtask

    task automatic test_full();
        idle();
        ls_req_valid = 1'b1; ls_req_a = 32'h500;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (ls_req_ready !== 1'b1) begin
                bad++;
                $display("FAIL full_issue c=%0d ls_rdy=%b want 1", c, ls_req_ready);
            end
            tick();
        end
        #1;
        total++;
        if (mem_req_valid !== 1'b0 || ls_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_block v=%b ls_rdy=%b want 0 0", mem_req_valid, ls_req_ready);
        end
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h61;
        #1;
        total++;
        if (ls_resp_valid !== 1'b1 || ls_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_no_issue ls_v=%b ls_rdy=%b req_v=%b want 1 0 0", ls_resp_valid, ls_req_ready, mem_req_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        total++;
        if (ls_req_ready !== 1'b1 || mem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL full_resume ls_rdy=%b req_v=%b want 1 1", ls_req_ready, mem_req_valid);
        end
        tick();
        ls_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h62;
        #1;
        total++;
        if (ls_resp_valid !== 1'b1 || ls_resp_data !== 32'h62) begin
            bad++;
            $display("FAIL full_drain1 ls_v=%b data=%h want 1 00000062", ls_resp_valid, ls_resp_data);
        end
        tick();
        mem_resp_data = 32'h63;
        #1;
        total++;
        if (ls_resp_valid !== 1'b1 || ls_resp_data !== 32'h63) begin
            bad++;
            $display("FAIL full_drain2 ls_v=%b data=%h want 1 00000063", ls_resp_valid, ls_resp_data);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle();
        if_req_valid = 1'b1; if_req_a = 32'h1000;
        #1;
        total++;
        if (if_req_ready !== 1'b1 || mem_req_a !== 32'h1000) begin
            bad++;
            $display("FAIL flush_fetch0 if_rdy=%b a=%h want 1 00001000", if_req_ready, mem_req_a);
        end
        tick();
        if_req_a = 32'h1004;
        #1;
        total++;
        if (if_req_ready !== 1'b1 || mem_req_a !== 32'h1004) begin
            bad++;
            $display("FAIL flush_fetch1 if_rdy=%b a=%h want 1 00001004", if_req_ready, mem_req_a);
        end
        tick();
        if_req_valid = 1'b0; flush = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0;
        #1;
        total++;
        if (if_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_head_same_cycle if_v=%b rdy=%b want 0 1", if_resp_valid, mem_resp_ready);
        end
        tick();
        flush = 1'b0; mem_resp_data = 32'hBAD1;
        if_req_valid = 1'b1; if_req_a = 32'h3000;
        #1;
        total++;
        if (if_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1 || if_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_killed_entry if_v=%b rdy=%b if_req_rdy=%b want 0 1 1", if_resp_valid, mem_resp_ready, if_req_ready);
        end
        tick();
        if_req_valid = 1'b0; mem_resp_data = 32'h30000D0D;
        #1;
        total++;
        if (if_resp_valid !== 1'b1 || if_resp_data !== 32'h30000D0D) begin
            bad++;
            $display("FAIL flush_next_fetch if_v=%b data=%h want 1 30000d0d", if_resp_valid, if_resp_data);
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        if_req_valid = 1'b1; if_req_a = 32'h2010;
        tick();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b1; ls_req_a = 32'h400;
        tick();
        ls_req_valid = 1'b0;
        if_resp_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (if_resp_valid !== 1'b1 || mem_resp_ready !== 1'b0 || ls_resp_valid !== 1'b0 || if_resp_data !== 32'h77) begin
                bad++;
                $display("FAIL bp_hold c=%0d if_v=%b rdy=%b ls_v=%b data=%h want 1 0 0 00000077", c, if_resp_valid, mem_resp_ready, ls_resp_valid, if_resp_data);
            end
            tick();
        end
        if_resp_ready = 1'b1;
        #1;
        total++;
        if (if_resp_valid !== 1'b1 || mem_resp_ready !== 1'b1 || ls_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release if_v=%b rdy=%b ls_v=%b want 1 1 0", if_resp_valid, mem_resp_ready, ls_resp_valid);
        end
        tick();
        mem_resp_data = 32'h88;
        #1;
        total++;
        if (ls_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || ls_resp_data !== 32'h88) begin
            bad++;
            $display("FAIL bp_ls_after ls_v=%b if_v=%b data=%h want 1 0 00000088", ls_resp_valid, if_resp_valid, ls_resp_data);
        end
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Arbitrates requests round-robin, locks a grant until handshake, and records per-request owner in an in-order tracking queue.
- Routes each in-order memory response back to its owner; discards responses to fetches killed by flush.
- Sits between instr_fetch / mem stage and the memory bus; replaces direct wiring of instr_fetch mem_req/mem_resp.

Parameters:
- XLEN, 32, address/data width
- MAX_OUTSTANDING, 2, tracking-queue depth = max accepted-but-unanswered requests (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- flush  in  1  pipeline flush; kills in-flight fetches
- if_req_valid/if_req_ready  in/out  1/1  IF request handshake
- if_req_a  in  XLEN  IF address (IF is read-only: we=0, be/d don't-care)
- ls_req_valid/ls_req_ready  in/out  1/1  LS request handshake
- ls_req_a, ls_req_d  in  XLEN  LS address, write data
- ls_req_we  in  1  write enable
- ls_req_be  in  XLEN/8  byte enables
- mem_req_valid/mem_req_ready  out/in  1/1  memory request handshake
- mem_req_a, mem_req_d  out  XLEN  forwarded address, write data
- mem_req_we  out  1;  mem_req_be  out  XLEN/8
- mem_resp_valid/mem_resp_ready  in/out  1/1  memory response handshake (in request order)
- mem_resp_data  in  XLEN  response data
- if_resp_valid/if_resp_ready  out/in  1/1;  if_resp_data  out  XLEN
- ls_resp_valid/ls_resp_ready  out/in  1/1;  ls_resp_data  out  XLEN

Behaviour:
- Reset (rst=0 at posedge): queue count=0, lock=0, last_grant=IF (LS wins first tie), all entries cleared. While reset is asserted and in the cycle after: mem_req_valid=0, if/ls_resp_valid=0, if/ls_req_ready=0. Reset mid-operation drops all tracking; later stray responses are illegal.
- Issue allowed only when count < MAX_OUTSTANDING; a pop in the same cycle does not free a slot for issue.
- Arbitration when unlocked: both valid -> grant opposite of last_grant; one valid -> grant it. IF treated as not valid when flush=1.
- Grant drives mem_req_* combinationally from the granted requester (IF: we=0, be=0, d=0). mem_req_valid = granted valid && issue allowed.
- Granted req_ready = mem_req_ready && issue allowed; the non-granted req_ready=0.
- Lock: if mem_req_valid && !mem_req_ready, set lock=1 and hold grant until fire. Exception: locked IF with flush=1 releases the lock and deasserts mem_req_valid (IF retracts on flush); LS is never retracted.
- On mem_req fire: push {owner, kill=0}, last_grant<=owner, lock<=0.
- Response routing by head entry: kill=1 -> mem_resp_ready=1, both resp_valid=0, entry popped on mem_resp_valid. Otherwise owner's resp_valid=mem_resp_valid, resp_data=mem_resp_data, mem_resp_ready=owner's resp_ready; other resp_valid=0. Pop on fire. Zero added latency.
- flush=1: every queued IF entry gets kill=1 at posedge, including an IF entry pushed the same cycle (impossible by rule above, but required). The IF response at head in the flush cycle is still suppressed combinationally (if_resp_valid=0, consumed). LS entries unaffected.
- Simultaneous push and pop: count unchanged, both take effect.
- mem_resp_valid with count=0: illegal; assertion fires; response ignored with mem_resp_ready=0.
- Queue implemented as circular buffer; pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
- Reset with rst=0 for 2 cycles while if_req_valid=ls_req_valid=1 -> mem_req_valid=0, no resp_valid; after release the first grant goes to LS (a=0x100), then IF (a=0x2000).
- Both requesters valid continuously, mem_req_ready=1, responses 1-cycle later -> grants alternate LS,IF,LS,IF; each response data reaches the correct owner in order.
- LS store (we=1, be=0xF, d=0xDEADBEEF) with mem_req_ready=0 for 3 cycles while IF valid -> mem_req_* stable on LS fields, IF ready=0 until fire.
- MAX_OUTSTANDING=2, mem_resp_valid held 0 -> exactly 2 fires then all req_ready=0; one response pops -> next cycle issue resumes.
- IF fetches 0x1000, 0x1004 outstanding, flush pulsed -> both responses consumed with if_resp_valid=0; following fetch 0x3000 response delivered.
- Responses with if_resp_ready=0 for 4 cycles -> mem_resp_ready=0, data held; LS response queued behind it not delivered early.
